button_debouncer: RTL and testbench

//  Front-end conditioning stage for the board push-buttons; sits directly upstream of the

---
 rtl/button_debouncer_pkg.sv | 30 +++
 rtl/button_debouncer_debounce_channel.sv | 149 ++++++++++++++
 rtl/button_debouncer.sv | 40 ++++
 tb/tb_button_debouncer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button front end: board clock, pin polarity,
// repeat FSM encoding and small constant helpers used to size counters.
package button_debouncer_pkg;

    // Board clock and raw pin polarity.
    localparam int   CLK_HZ      = 12_000_000;
    localparam logic BTN_PRESSED = 1'b0;

    // Per-channel auto-repeat state; the encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Convert a duration in milliseconds to clk cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter that accepts a
// change only after it has been stable long enough, and an auto-repeat FSM
// that turns a long hold into a stream of press pulses.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = ms_to_cycles(10),
    parameter int REPEAT_EN      = 1,
    parameter int REPEAT_DLY_CYC = ms_to_cycles(500),
    parameter int REPEAT_PER_CYC = ms_to_cycles(100)
) (
    input  logic       clk,
    input  logic       rst_button,
    input  logic       button,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [1:0] state
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam int RPT_W = cnt_width(max_int(REPEAT_DLY_CYC, REPEAT_PER_CYC));

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY_CYC - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             sample;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             accept_press;
    logic             accept_release;

    rpt_state_t       rpt_state_q;
    rpt_state_t       rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             press_d;
    logic             release_d;
    logic             press_q;
    logic             release_q;

    // Bring the asynchronous pin into the clk domain; reset to the released level.
    always_ff @(posedge clk or negedge rst_button) begin
        if (!rst_button) begin
            sync_q1 <= ~BTN_PRESSED;
            sync_q2 <= ~BTN_PRESSED;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    // Internally 1 means pressed regardless of pin polarity.
    assign sample = (sync_q2 == BTN_PRESSED);

    // A change is accepted on the last cycle of an unbroken run of differing samples.
    assign accept         = (sample != stable_q) && (cnt_q == CNT_LAST);
    assign accept_press   = accept && sample;
    assign accept_release = accept && !sample;

    // Debounce counter: restarts whenever the sample agrees with the accepted state.
    always_ff @(posedge clk or negedge rst_button) begin
        if (!rst_button) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else if (sample == stable_q) begin
            cnt_q <= '0;
        end else if (accept) begin
            stable_q <= ~stable_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Repeat FSM state, repeat counter and registered pulses, which line up with
    // the cycle in which stable_q first shows the new level.
    always_ff @(posedge clk or negedge rst_button) begin
        if (!rst_button) begin
            rpt_state_q <= ST_IDLE;
            rpt_cnt_q   <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    // Next state: release takes priority over a repeat expiry in the same cycle.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        case (rpt_state_q)
            ST_IDLE: begin
                if (accept_press) begin
                    rpt_state_d = ST_HELD;
                    rpt_cnt_d   = '0;
                    press_d     = 1'b1;
                end
            end
            ST_HELD: begin
                if (accept_release) begin
                    rpt_state_d = ST_IDLE;
                    rpt_cnt_d   = '0;
                    release_d   = 1'b1;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_cnt_q == DLY_LAST) begin
                        rpt_state_d = ST_REPEAT;
                        rpt_cnt_d   = '0;
                        press_d     = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (accept_release) begin
                    rpt_state_d = ST_IDLE;
                    rpt_cnt_d   = '0;
                    release_d   = 1'b1;
                end else if (rpt_cnt_q == PER_LAST) begin
                    rpt_cnt_d = '0;
                    press_d   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                rpt_state_d = ST_IDLE;
                rpt_cnt_d   = '0;
            end
        endcase
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign state       = rpt_state_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioning front end: N independent debounce channels with
// level, press/release pulses and optional auto-repeat. The top only fans the
// vectors out to the per-channel instances.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_BTN          = 2,
    parameter int DEBOUNCE_CYC   = ms_to_cycles(10),
    parameter int REPEAT_EN      = 1,
    parameter int REPEAT_DLY_CYC = ms_to_cycles(500),
    parameter int REPEAT_PER_CYC = ms_to_cycles(100)
) (
    input  logic               clk,
    input  logic               rst_button,
    input  logic [N_BTN-1:0]   button,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [2*N_BTN-1:0] dbg_state
);

    // One channel per button; repeat FSM state of channel i sits in dbg_state[2*i+:2].
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYC   (DEBOUNCE_CYC),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DLY_CYC (REPEAT_DLY_CYC),
            .REPEAT_PER_CYC (REPEAT_PER_CYC)
        ) u_chan (
            .clk         (clk),
            .rst_button  (rst_button),
            .button      (button[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .state       (dbg_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with short timing parameters: a vector table for
// reset, first press, repeat and release, then hand sequences for bounce,
// repeat timing, release/repeat collisions and reset during repeat.
module tb_button_debouncer;

    localparam int W = 16;

    logic       clk;
    logic       rst_button;
    logic [1:0] button;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [3:0] dbg_state;

    int n_cmp;
    int n_fail;
    int cyc;

    logic [W-1:0] exp_q[$];
    int           press_log[$];
    int           release_log[$];

    typedef struct {
        logic       rst_n;
        logic [1:0] button;
        int         ncyc;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
    } vec_t;

    vec_t vecs[13];

    button_debouncer #(
        .N_BTN          (2),
        .DEBOUNCE_CYC   (8),
        .REPEAT_EN      (1),
        .REPEAT_DLY_CYC (32),
        .REPEAT_PER_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_button  (rst_button),
        .button      (button),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .dbg_state   (dbg_state)
    );

    // Clock and reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver and scoreboard tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read at the falling edge that follows.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_button = 1'b0;
        button     = 2'b11;
        repeat (3) step();
        rst_button = 1'b1;
        cyc        = 0;
    endtask

    task automatic run_log(input int n, input int ch);
        repeat (n) begin
            step();
            if (btn_press[ch])   press_log.push_back(cyc);
            if (btn_release[ch]) release_log.push_back(cyc);
        end
    endtask

    task automatic expect_evt(input int c);
        exp_q.push_back(W'(c));
    endtask

    task automatic compare_log(input string name, input bit use_rel);
        int got[$];
        if (use_rel) got = release_log;
        else         got = press_log;
        check({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic clear_logs();
        press_log.delete();
        release_log.delete();
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        cyc        = 0;
        button     = 2'b00;
        rst_button = 1'b1;
        #1 rst_button = 1'b0;

        // Both buttons held through reset: press after 2 sync + 8 debounce cycles,
        // repeats at 42 and 50, release accepted 10 cycles after the pins go high.
        vecs[0]  = '{1'b0, 2'b00,  3, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 2'b00,  9, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 2'b00,  1, 2'b11, 2'b11, 2'b00};
        vecs[3]  = '{1'b1, 2'b00,  1, 2'b11, 2'b00, 2'b00};
        vecs[4]  = '{1'b1, 2'b00, 30, 2'b11, 2'b00, 2'b00};
        vecs[5]  = '{1'b1, 2'b00,  1, 2'b11, 2'b11, 2'b00};
        vecs[6]  = '{1'b1, 2'b00,  1, 2'b11, 2'b00, 2'b00};
        vecs[7]  = '{1'b1, 2'b00,  7, 2'b11, 2'b11, 2'b00};
        vecs[8]  = '{1'b1, 2'b11,  7, 2'b11, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, 2'b11,  1, 2'b11, 2'b11, 2'b00};
        vecs[10] = '{1'b1, 2'b11,  1, 2'b11, 2'b00, 2'b00};
        vecs[11] = '{1'b1, 2'b11,  1, 2'b00, 2'b00, 2'b11};
        vecs[12] = '{1'b1, 2'b11,  1, 2'b00, 2'b00, 2'b00};

        for (int i = 0; i < 13; i++) begin
            rst_button = vecs[i].rst_n;
            button     = vecs[i].button;
            repeat (vecs[i].ncyc) step();
            check($sformatf("vec%0d level", i),   btn_level,   vecs[i].level);
            check($sformatf("vec%0d press", i),   btn_press,   vecs[i].press);
            check($sformatf("vec%0d release", i), btn_release, vecs[i].rel);
            if (i == 0) check("reset state", dbg_state, 4'h0);
        end

        // Bounce on button 0: toggling every 3 cycles never completes a debounce.
        do_reset();
        clear_logs();
        for (int seg = 0; seg < 10; seg++) begin
            button = (seg % 2 == 0) ? 2'b10 : 2'b11;
            run_log(3, 0);
        end
        compare_log("bounce press", 1'b0);
        compare_log("bounce release", 1'b1);
        check("bounce level", btn_level, 2'b00);
        clear_logs();
        button = 2'b10;
        cyc    = 0;
        run_log(12, 0);
        expect_evt(10);
        compare_log("settle press", 1'b0);
        compare_log("settle release", 1'b1);
        check("settle level", btn_level, 2'b01);

        // Hold button 1: first press, delayed first repeat, then periodic repeats.
        do_reset();
        clear_logs();
        button = 2'b01;
        run_log(80, 1);
        expect_evt(10); expect_evt(42); expect_evt(50);
        expect_evt(58); expect_evt(66); expect_evt(74);
        compare_log("repeat press", 1'b0);
        compare_log("repeat release", 1'b1);
        check("repeat level", btn_level, 2'b10);
        check("repeat state", dbg_state, 4'h8);

        // Release from REPEAT; acceptance at cycle 90 coincides with a repeat expiry.
        clear_logs();
        button = 2'b11;
        run_log(30, 1);
        expect_evt(82);
        compare_log("rel-repeat press", 1'b0);
        expect_evt(90);
        compare_log("rel-repeat release", 1'b1);
        check("rel-repeat level", btn_level, 2'b00);
        check("rel-repeat state", dbg_state, 4'h0);

        // Release from HELD accepted on the same cycle the first repeat would fire.
        do_reset();
        clear_logs();
        button = 2'b01;
        run_log(32, 1);
        expect_evt(10);
        compare_log("held press", 1'b0);
        clear_logs();
        button = 2'b11;
        run_log(20, 1);
        compare_log("held collision press", 1'b0);
        expect_evt(42);
        compare_log("held collision release", 1'b1);

        // Reset during REPEAT: outputs drop at once; a held button re-debounces.
        do_reset();
        button = 2'b10;
        repeat (45) step();
        check("pre-reset state", dbg_state, 4'h2);
        check("pre-reset level", btn_level, 2'b01);
        #2 rst_button = 1'b0;
        #1;
        check("mid-reset level", btn_level, 2'b00);
        check("mid-reset press", btn_press, 2'b00);
        check("mid-reset release", btn_release, 2'b00);
        check("mid-reset state", dbg_state, 4'h0);
        @(negedge clk);
        step();
        rst_button = 1'b1;
        cyc        = 0;
        repeat (9) step();
        check("post-reset level early", btn_level, 2'b00);
        step();
        check("post-reset level", btn_level, 2'b01);
        check("post-reset press", btn_press, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
